// File: rtl/cve2_rf_wb_queue_pkg.sv
// Shared types and helpers for the register-file writeback queue.
//   wb_entry_t    : one queued result (destination register + data), default 32-bit data
//   onehot_reg    : 32-bit one-hot decode of a register address
//   addr_is_zero  : true when an address behaves as x0 (bit 4 set also counts under RV32E)
package cve2_wb_pkg;

  localparam int unsigned WbDataWidth = 32;

  typedef struct packed {
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
  } wb_entry_t;

  function automatic logic [31:0] onehot_reg(input logic [4:0] addr);
    logic [31:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

  function automatic logic addr_is_zero(input logic [4:0] addr, input logic rv32e);
    if (rv32e) begin
      return addr[4] || (addr[3:0] == 4'd0);
    end
    return addr == 5'd0;
  endfunction

endpackage

// File: rtl/cve2_wb_fifo2.sv
// Dual-push / dual-pop circular buffer with occupancy count.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push0_i/push0_data_i : older entry to enqueue
//   push1_i/push1_data_i : younger entry, only meaningful together with push0_i
//   pop_num_i            : number of entries removed from the head (0..2)
//   head0_o / head1_o    : oldest and second-oldest entries
//   entries_o / valid_o  : raw storage and per-slot occupancy
//   count_o              : occupied entries
// The caller guarantees it never pushes into a full buffer or pops more than count_o.
module cve2_wb_fifo2 import cve2_wb_pkg::*; #(
  parameter int unsigned Depth = 4,
  parameter type entry_t = wb_entry_t,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push0_i,
  input  entry_t          push0_data_i,
  input  logic            push1_i,
  input  entry_t          push1_data_i,
  input  logic [1:0]      pop_num_i,
  output entry_t          head0_o,
  output entry_t          head1_o,
  output entry_t          entries_o [Depth],
  output logic [Depth-1:0] valid_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_nx;
  logic [PtrW-1:0] offset;
  logic [CntW-1:0] count_q, count_d;
  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (push0_i) begin
      mem_d[wptr_d] = push0_data_i;
      wptr_d        = wptr_d + 1'b1;
    end
    if (push1_i) begin
      mem_d[wptr_d] = push1_data_i;
      wptr_d        = wptr_d + 1'b1;
    end
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    rptr_d  = rptr_q + PtrW'(pop_num_i);
    count_d = count_q + CntW'(push0_i) + CntW'(push1_i) - CntW'(pop_num_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: slots are only observed when valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rptr_nx   = rptr_q + 1'b1;
  assign head0_o   = mem_q[rptr_q];
  assign head1_o   = mem_q[rptr_nx];
  assign entries_o = mem_q;
  assign count_o   = count_q;

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    offset  = '0;
    valid_o = '0;
    for (int i = 0; i < Depth; i++) begin
      offset     = PtrW'(i) - rptr_q;
      valid_o[i] = {1'b0, offset} < count_q;
    end
  end

endmodule

// File: rtl/cve2_rf_wb_queue.sv
// Writeback queue feeding the two write ports of the flip-flop register file.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   p0_* (execute), p1_* (LSU): valid/ready result producers
//   waddr/wdata/we_a_o, _b_o  : register file write ports (A wins on equal address)
//   pending_o                 : bit i set while a queued entry targets register i
//   count_o, empty_o          : occupancy
// Results are kept in program order; up to two retire per cycle. All write-port
// and status outputs come from registered state only.
module cve2_rf_wb_queue import cve2_wb_pkg::*; #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  localparam int unsigned CntW     = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 p0_valid_i,
  output logic                 p0_ready_o,
  input  logic [4:0]           p0_addr_i,
  input  logic [DataWidth-1:0] p0_data_i,
  input  logic                 p1_valid_i,
  output logic                 p1_ready_o,
  input  logic [4:0]           p1_addr_i,
  input  logic [DataWidth-1:0] p1_data_i,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic [4:0]           waddr_b_o,
  output logic [DataWidth-1:0] wdata_b_o,
  output logic                 we_b_o,
  output logic [31:0]          pending_o,
  output logic [CntW-1:0]      count_o,
  output logic                 empty_o
);

  // Same layout as wb_entry_t, sized to this instance's data width.
  typedef struct packed {
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  localparam logic [CntW-1:0] DepthC   = CntW'(Depth);
  localparam logic [CntW-1:0] DepthM1C = CntW'(Depth - 1);

  logic [CntW-1:0]  count;
  logic             p0_store, p1_store;
  logic             push0, push1;
  entry_t           push0_data, push1_data;
  logic [1:0]       pop_num;
  entry_t           head0, head1;
  entry_t           entries [Depth];
  logic [Depth-1:0] valid;
  logic [31:0]      pend_vec;

  // Readiness uses the registered count only; p0 must leave room for p1
  // whenever p1 is also offering a result, since p1 is enqueued first.
  assign p1_ready_o = count < DepthC;
  assign p0_ready_o = p1_valid_i ? (count < DepthM1C) : (count < DepthC);

  // x0 writes (and x16..x31 under RV32E) complete the handshake but are dropped.
  assign p1_store = p1_valid_i && p1_ready_o && !addr_is_zero(p1_addr_i, RV32E);
  assign p0_store = p0_valid_i && p0_ready_o && !addr_is_zero(p0_addr_i, RV32E);

  // Compact the pushes so the older stored result always lands in slot 0.
  always_comb begin
    push0      = p1_store || p0_store;
    push1      = p1_store && p0_store;
    push0_data = p1_store ? entry_t'{addr: p1_addr_i, data: p1_data_i}
                          : entry_t'{addr: p0_addr_i, data: p0_data_i};
    push1_data = entry_t'{addr: p0_addr_i, data: p0_data_i};
  end

  cve2_wb_fifo2 #(
    .Depth   (Depth),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push0_i      (push0),
    .push0_data_i (push0_data),
    .push1_i      (push1),
    .push1_data_i (push1_data),
    .pop_num_i    (pop_num),
    .head0_o      (head0),
    .head1_o      (head1),
    .entries_o    (entries),
    .valid_o      (valid),
    .count_o      (count)
  );

  // With two entries the older goes on B and the younger on A, so the
  // register file's A-priority leaves the younger value on an address clash.
  always_comb begin
    we_a_o    = 1'b0;
    waddr_a_o = '0;
    wdata_a_o = '0;
    we_b_o    = 1'b0;
    waddr_b_o = '0;
    wdata_b_o = '0;
    pop_num   = 2'd0;
    if (count == CntW'(1)) begin
      we_a_o    = 1'b1;
      waddr_a_o = head0.addr;
      wdata_a_o = head0.data;
      pop_num   = 2'd1;
    end else if (count >= CntW'(2)) begin
      we_a_o    = 1'b1;
      waddr_a_o = head1.addr;
      wdata_a_o = head1.data;
      we_b_o    = 1'b1;
      waddr_b_o = head0.addr;
      wdata_b_o = head0.data;
      pop_num   = 2'd2;
    end
  end

  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < Depth; i++) begin
      if (valid[i]) begin
        pend_vec = pend_vec | onehot_reg(entries[i].addr);
      end
    end
  end

  assign pending_o = {pend_vec[31:1], 1'b0};
  assign count_o   = count;
  assign empty_o   = (count == '0);

endmodule

// File: tb/tb_cve2_rf_wb_queue.sv
`timescale 1ns/1ps
module tb_cve2_rf_wb_queue;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_valid = 1'b0, p1_valid = 1'b0;
  logic [4:0]  p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_data = '0, p1_data = '0;

  // Index 0: RV32E=0, Depth=4.  Index 1: RV32E=1, Depth=2.
  logic        p0_rdy [2], p1_rdy [2], we_a [2], we_b [2], empty [2];
  logic [4:0]  waddr_a [2], waddr_b [2];
  logic [31:0] wdata_a [2], wdata_b [2], pend [2];
  logic [2:0]  cnt0;
  logic [1:0]  cnt1;
  logic [2:0]  dcnt [2];
  assign dcnt[0] = cnt0;
  assign dcnt[1] = {1'b0, cnt1};

  cve2_rf_wb_queue #(.RV32E(1'b0), .DataWidth(32), .Depth(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_valid_i(p0_valid), .p0_ready_o(p0_rdy[0]), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
    .p1_valid_i(p1_valid), .p1_ready_o(p1_rdy[0]), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .waddr_a_o(waddr_a[0]), .wdata_a_o(wdata_a[0]), .we_a_o(we_a[0]),
    .waddr_b_o(waddr_b[0]), .wdata_b_o(wdata_b[0]), .we_b_o(we_b[0]),
    .pending_o(pend[0]), .count_o(cnt0), .empty_o(empty[0]));

  cve2_rf_wb_queue #(.RV32E(1'b1), .DataWidth(32), .Depth(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_valid_i(p0_valid), .p0_ready_o(p0_rdy[1]), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
    .p1_valid_i(p1_valid), .p1_ready_o(p1_rdy[1]), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .waddr_a_o(waddr_a[1]), .wdata_a_o(wdata_a[1]), .we_a_o(we_a[1]),
    .waddr_b_o(waddr_b[1]), .wdata_b_o(wdata_b[1]), .we_b_o(we_b[1]),
    .pending_o(pend[1]), .count_o(cnt1), .empty_o(empty[1]));

  // Register file image built from instance 0's write ports; A is applied last.
  logic [31:0] rf0 [32];
  always @(posedge clk) begin
    if (we_b[0]) rf0[waddr_b[0]] <= wdata_b[0];
    if (we_a[0]) rf0[waddr_a[0]] <= wdata_a[0];
  end

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboard: per-instance ordered queue of expected retirements.
  logic [4:0]  m_addr [2][4];
  logic [31:0] m_data [2][4];
  int          m_head [2];
  int          m_cnt  [2];

  logic        exp_we_a [2], exp_we_b [2], exp_rdy0 [2], exp_rdy1 [2];
  logic [4:0]  exp_waddr_a [2], exp_waddr_b [2];
  logic [31:0] exp_wdata_a [2], exp_wdata_b [2], exp_pend [2];
  int          exp_cnt [2];

  function automatic int mdepth(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic bit m_zero(input int k, input logic [4:0] a);
    if (k == 1) return a[4] || (a[3:0] == 4'd0);
    return a == 5'd0;
  endfunction

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic model_eval;
    for (int k = 0; k < 2; k++) begin
      int d, c, h;
      d = mdepth(k); c = m_cnt[k]; h = m_head[k];
      exp_we_a[k] = (c >= 1);
      exp_we_b[k] = (c >= 2);
      exp_waddr_a[k] = '0; exp_wdata_a[k] = '0;
      exp_waddr_b[k] = '0; exp_wdata_b[k] = '0;
      if (c == 1) begin
        exp_waddr_a[k] = m_addr[k][h]; exp_wdata_a[k] = m_data[k][h];
      end else if (c >= 2) begin
        exp_waddr_b[k] = m_addr[k][h]; exp_wdata_b[k] = m_data[k][h];
        exp_waddr_a[k] = m_addr[k][(h + 1) % d]; exp_wdata_a[k] = m_data[k][(h + 1) % d];
      end
      exp_pend[k] = '0;
      for (int i = 0; i < c; i++) exp_pend[k][m_addr[k][(h + i) % d]] = 1'b1;
      exp_cnt[k]  = c;
      exp_rdy1[k] = (c < d);
      exp_rdy0[k] = p1_valid ? (c < d - 1) : (c < d);
    end
  endtask

  task automatic model_step;
    for (int k = 0; k < 2; k++) begin
      int d, c, h, t, pu, po;
      d = mdepth(k); c = m_cnt[k]; h = m_head[k];
      t = (h + c) % d; pu = 0;
      if (p1_valid && exp_rdy1[k] && !m_zero(k, p1_addr)) begin
        m_addr[k][(t + pu) % d] = p1_addr; m_data[k][(t + pu) % d] = p1_data; pu++;
      end
      if (p0_valid && exp_rdy0[k] && !m_zero(k, p0_addr)) begin
        m_addr[k][(t + pu) % d] = p0_addr; m_data[k][(t + pu) % d] = p0_data; pu++;
      end
      po = (c < 2) ? c : 2;
      m_head[k] = (h + po) % d;
      m_cnt[k]  = c - po + pu;
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    #1;
    model_eval;
  endtask

  task automatic advance;
    model_step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      advance;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    model_reset;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (dcnt[k] !== 3'd0) begin n_fails++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, dcnt[k]); end
      n_checks++; if (empty[k] !== 1'b1) begin n_fails++; $display("FAIL reset_empty[%0d]: got %0b expected 1", k, empty[k]); end
      n_checks++; if ({we_a[k], we_b[k]} !== 2'b00) begin n_fails++; $display("FAIL reset_we[%0d]: got %b expected 00", k, {we_a[k], we_b[k]}); end
      n_checks++; if (pend[k] !== 32'd0) begin n_fails++; $display("FAIL reset_pending[%0d]: got %h expected 0", k, pend[k]); end
      n_checks++; if ({waddr_a[k], waddr_b[k], wdata_a[k], wdata_b[k]} !== '0) begin n_fails++; $display("FAIL reset_ports[%0d]: got nonzero address/data, expected 0", k); end
      n_checks++; if ({p0_rdy[k], p1_rdy[k]} !== 2'b11) begin n_fails++; $display("FAIL reset_ready[%0d]: got %b expected 11", k, {p0_rdy[k], p1_rdy[k]}); end
    end
  endtask

  task automatic test_single;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p0_rdy[k] !== 1'b1) begin n_fails++; $display("FAIL single_p0_ready[%0d]: got %b expected 1", k, p0_rdy[k]); end
    end
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if ({we_a[k], we_b[k]} !== 2'b10) begin n_fails++; $display("FAIL single_we[%0d]: got %b expected 10", k, {we_a[k], we_b[k]}); end
      n_checks++; if (waddr_a[k] !== 5'd5 || wdata_a[k] !== 32'hDEADBEEF) begin n_fails++; $display("FAIL single_port_a[%0d]: got %0d/%h expected 5/deadbeef", k, waddr_a[k], wdata_a[k]); end
      n_checks++; if (pend[k] !== 32'h20) begin n_fails++; $display("FAIL single_pending[%0d]: got %h expected 00000020", k, pend[k]); end
    end
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (pend[k] !== 32'd0 || empty[k] !== 1'b1) begin n_fails++; $display("FAIL single_drained[%0d]: got pending %h empty %b expected 0/1", k, pend[k], empty[k]); end
    end
  endtask

  task automatic test_same_addr_pair;
    drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11);
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (!(we_b[k] === 1'b1 && waddr_b[k] === 5'd3 && wdata_b[k] === 32'h11)) begin n_fails++; $display("FAIL pair_port_b[%0d]: got %b %0d/%h expected 1 3/11", k, we_b[k], waddr_b[k], wdata_b[k]); end
      n_checks++; if (!(we_a[k] === 1'b1 && waddr_a[k] === 5'd3 && wdata_a[k] === 32'h22)) begin n_fails++; $display("FAIL pair_port_a[%0d]: got %b %0d/%h expected 1 3/22", k, we_a[k], waddr_a[k], wdata_a[k]); end
    end
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++; if (rf0[3] !== 32'h22) begin n_fails++; $display("FAIL pair_rf_x3: got %h expected 00000022", rf0[3]); end
  endtask

  task automatic test_x0;
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (p0_rdy[k] !== 1'b1) begin n_fails++; $display("FAIL x0_ready[%0d]: got %b expected 1", k, p0_rdy[k]); end
    end
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (dcnt[k] !== 3'd0) begin n_fails++; $display("FAIL x0_count[%0d]: got %0d expected 0", k, dcnt[k]); end
      n_checks++; if ({we_a[k], we_b[k]} !== 2'b00) begin n_fails++; $display("FAIL x0_we[%0d]: got %b expected 00", k, {we_a[k], we_b[k]}); end
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 40; n++) begin
      logic v0, v1;
      logic [4:0] a0, a1;
      v0 = (n < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      v1 = (n < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      a0 = (n < 6) ? 5'(n + 1) : 5'($urandom_range(0, 31));
      a1 = (n < 6) ? 5'(n + 9) : 5'($urandom_range(0, 31));
      drive(v0, a0, $urandom, v1, a1, $urandom);
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (p0_rdy[k] !== exp_rdy0[k] || p1_rdy[k] !== exp_rdy1[k]) begin n_fails++; $display("FAIL b2b_ready[%0d] n=%0d: got %b%b expected %b%b", k, n, p0_rdy[k], p1_rdy[k], exp_rdy0[k], exp_rdy1[k]); end
        n_checks++; if (dcnt[k] !== 3'(exp_cnt[k]) || empty[k] !== (exp_cnt[k] == 0)) begin n_fails++; $display("FAIL b2b_count[%0d] n=%0d: got %0d expected %0d", k, n, dcnt[k], exp_cnt[k]); end
        n_checks++; if ({we_a[k], waddr_a[k], wdata_a[k]} !== {exp_we_a[k], exp_waddr_a[k], exp_wdata_a[k]}) begin n_fails++; $display("FAIL b2b_port_a[%0d] n=%0d: got %b %0d/%h expected %b %0d/%h", k, n, we_a[k], waddr_a[k], wdata_a[k], exp_we_a[k], exp_waddr_a[k], exp_wdata_a[k]); end
        n_checks++; if ({we_b[k], waddr_b[k], wdata_b[k]} !== {exp_we_b[k], exp_waddr_b[k], exp_wdata_b[k]}) begin n_fails++; $display("FAIL b2b_port_b[%0d] n=%0d: got %b %0d/%h expected %b %0d/%h", k, n, we_b[k], waddr_b[k], wdata_b[k], exp_we_b[k], exp_waddr_b[k], exp_wdata_b[k]); end
        n_checks++; if (pend[k] !== exp_pend[k]) begin n_fails++; $display("FAIL b2b_pending[%0d] n=%0d: got %h expected %h", k, n, pend[k], exp_pend[k]); end
      end
      advance;
    end
    idle_cycles(3);
  endtask

  task automatic test_async_reset;
    drive(1'b1, 5'd9, 32'hB, 1'b1, 5'd7, 32'hA);
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (dcnt[k] !== 3'd2) begin n_fails++; $display("FAIL areset_pre_count[%0d]: got %0d expected 2", k, dcnt[k]); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (dcnt[k] !== 3'd0 || empty[k] !== 1'b1) begin n_fails++; $display("FAIL areset_count[%0d]: got %0d expected 0", k, dcnt[k]); end
      n_checks++; if (pend[k] !== 32'd0) begin n_fails++; $display("FAIL areset_pending[%0d]: got %h expected 0", k, pend[k]); end
      n_checks++; if ({we_a[k], we_b[k]} !== 2'b00) begin n_fails++; $display("FAIL areset_we[%0d]: got %b expected 00", k, {we_a[k], we_b[k]}); end
    end
    model_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (!(we_a[k] === 1'b1 && we_b[k] === 1'b0 && waddr_a[k] === 5'd5 && wdata_a[k] === 32'hDEADBEEF)) begin n_fails++; $display("FAIL areset_first_push[%0d]: got %b%b %0d/%h expected 10 5/deadbeef", k, we_a[k], we_b[k], waddr_a[k], wdata_a[k]); end
    end
    idle_cycles(2);
  endtask

  task automatic test_rv32e;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'b10010, 32'h9);
    n_checks++; if (p1_rdy[1] !== 1'b1) begin n_fails++; $display("FAIL rv32e_ready: got %b expected 1", p1_rdy[1]); end
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++; if (dcnt[1] !== 3'd0 || we_a[1] !== 1'b0) begin n_fails++; $display("FAIL rv32e_not_stored: got count %0d we_a %b expected 0/0", dcnt[1], we_a[1]); end
    n_checks++; if (pend[1] !== 32'd0) begin n_fails++; $display("FAIL rv32e_pending: got %h expected 0", pend[1]); end
    n_checks++; if (!(we_a[0] === 1'b1 && waddr_a[0] === 5'd18 && pend[0] === 32'h0004_0000)) begin n_fails++; $display("FAIL rv32i_x18: got %b %0d pending %h expected 1 18 00040000", we_a[0], waddr_a[0], pend[0]); end
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'b00010, 32'h7);
    advance;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++; if (!(we_a[1] === 1'b1 && waddr_a[1] === 5'd2 && wdata_a[1] === 32'h7)) begin n_fails++; $display("FAIL rv32e_x2: got %b %0d/%h expected 1 2/7", we_a[1], waddr_a[1], wdata_a[1]); end
    idle_cycles(2);
  endtask

  initial begin
    test_reset;
    test_single;
    test_same_addr_pair;
    test_x0;
    test_back_to_back;
    test_async_reset;
    test_rv32e;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
